decode_branch: RTL and testbench
================================

Name: decode_branch

Overview:
- Consumer end of the fetch interface: takes the ROM instruction word and the current PC each cycle, and decodes opcode/register/immediate for execute.
- Resolves JMP/BZ/BNZ/HALT and drives the redirect back to fetch through sel and PC_disp.
- Tracks synchronous-ROM latency, discards wrong-path words after a redirect, and freezes the pipe on HALT.

Parameters:
FLUSH_CYCLES, 1, number of instruction words discarded after a taken redirect (1..3)
HALT_OP, 4'hF, opcode value treated as HALT

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
PC  input  8  PC presented to i_rom this cycle (from fetch)
inst  input  16  i_rom output; belongs to the PC of the previous cycle
z_flag  input  1  zero flag from execute, valid in the cycle it is sampled
sel  output  1  1 = fetch loads PC_disp, 0 = fetch increments
PC_disp  output  9  redirect target, {1'b0, target[7:0]}
dec_valid  output  1  decoded fields valid for execute this cycle
dec_op  output  4  inst[15:12]
dec_rd  output  4  inst[11:8]
dec_imm  output  8  inst[7:0]
halted  output  1  HALT state flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=WAIT; pc_q=0; flush counter=0.
  - Outputs: sel=0, PC_disp=0, dec_valid=0, dec_op/dec_rd/dec_imm=0, halted=0.
- Every clock, pc_q<=PC, except in HALT, where pc_q holds. inst is paired with pc_q (1-cycle ROM latency).
- Decode (combinational from inst):
  - op=inst[15:12], rd=inst[11:8], disp=inst[7:0] as signed.
  - target = pc_q + sext(disp), truncated mod 256; wrap-around is legal (0x02 + 0xFC = 0xFE; 0xFE + 0x04 = 0x02).
- Branch rules, applied only in state RUN:
  - JMP (op 4'hC): taken.
  - BZ (op 4'hD): taken if z_flag=1.
  - BNZ (op 4'hE): taken if z_flag=0.
  - Taken: sel=1, PC_disp={1'b0,target} combinationally in the same cycle. Otherwise sel=0 and PC_disp=0.
- dec_valid/dec_op/dec_rd/dec_imm are registered, 1-cycle latency from inst.
  - dec_valid=1 only for words decoded in RUN, including the branch word itself.
  - Discarded words produce dec_valid=0, with fields zeroed.
- State machine:
  - WAIT: ROM output is stale for the first cycle after reset. Discard inst, sel=0, then go to RUN.
  - RUN:
    - Taken branch -> FLUSH, counter=FLUSH_CYCLES.
    - op==HALT_OP -> HALT.
    - Otherwise stay in RUN.
  - FLUSH: discard inst, sel=0, decrement counter; go to RUN when counter reaches 1. A branch opcode seen in FLUSH is ignored: no redirect, no nested flush.
  - HALT:
    - sel=1 and PC_disp={1'b0,pc_q}, re-fetching the HALT address indefinitely.
    - dec_valid=0, halted=1. HALT is left only by reset.
- Simultaneous events:
  - HALT word in RUN: HALT wins; dec_valid=1 for the HALT word itself.
  - Reset asserted in any state: immediate return to WAIT. An in-progress flush is abandoned; sel drops to 0 asynchronously.
- z_flag is sampled only in the cycle the BZ/BNZ word is in RUN; no internal flag storage.

Optional Feature:
- Macro DECODE_PERF_EN.
- Defined:
  - Adds output taken_cnt[15:0]: count of taken redirects, reset to 0, saturating at 16'hFFFF.
  - Adds output flush_cnt[15:0]: count of discarded words, including WAIT and FLUSH cycles but excluding HALT cycles; reset to 0, saturating at 16'hFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, PC=0x00 then 0x01, inst for addr0=16'h1234 -> first cycle WAIT with dec_valid=0 and sel=0; next cycle dec_valid=1, dec_op=1, dec_rd=2, dec_imm=0x34.
- JMP at pc_q=0x10, inst=16'hC005 -> same cycle sel=1, PC_disp=9'h015; next word has dec_valid=0; RUN resumes after 1 cycle (FLUSH_CYCLES=1).
- BZ at pc_q=0x02, inst=16'hD0FC: with z_flag=1 -> sel=1, PC_disp=9'h0FE; repeat with z_flag=0 -> sel=0, no flush.
- Wrap-around: BNZ at pc_q=0xFE, inst=16'hE004, z_flag=0 -> PC_disp=9'h002.
- HALT at pc_q=0x20, inst=16'hF000 -> dec_valid=1 for one cycle, then halted=1, sel=1, PC_disp=9'h020 every cycle. rst low mid-HALT -> all outputs 0 immediately, WAIT on release.
- FLUSH_CYCLES=2, JMP followed by a JMP word in the wrong path -> second JMP ignored (sel=0), 2 words discarded. With DECODE_PERF_EN: taken_cnt=1, flush_cnt=3 (1 WAIT + 2 flushed).

Source files
------------

// File: rtl/decode_branch.sv
// rtl/decode_branch.sv - decode stage: field decode, branch resolve, wrong-path flush, HALT freeze
// Optional build macro DECODE_PERF_EN adds taken_cnt/flush_cnt performance counters.
module decode_branch #(
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [3:0] HALT_OP      = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  PC,
  input  logic [15:0] inst,
  input  logic        z_flag,
  output logic        sel,
  output logic [8:0]  PC_disp,
  output logic        dec_valid,
  output logic [3:0]  dec_op,
  output logic [3:0]  dec_rd,
  output logic [7:0]  dec_imm,
  output logic        halted
`ifdef DECODE_PERF_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_BZ  = 4'hD;
  localparam logic [3:0] OP_BNZ = 4'hE;

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_FLUSH, S_HALT} state_t;

  state_t      state;
  logic [7:0]  pc_q;
  logic [1:0]  flush_left;
  logic [3:0]  op;
  logic [7:0]  target;
  logic        taken;
  logic        halt_now;

  assign op = inst[15:12];
  // Two's-complement add mod 256 is the same as pc_q + sext(disp) truncated to 8 bits.
  assign target = pc_q + inst[7:0];

  always_comb begin
    taken = 1'b0;
    if (state == S_RUN) begin
      case (op)
        OP_JMP:  taken = 1'b1;
        OP_BZ:   taken = z_flag;
        OP_BNZ:  taken = ~z_flag;
        default: taken = 1'b0;
      endcase
    end
  end

  assign halt_now = (state == S_RUN) && !taken && (op == HALT_OP);

  always_comb begin
    sel     = 1'b0;
    PC_disp = 9'd0;
    if (state == S_HALT) begin
      sel     = 1'b1;
      PC_disp = {1'b0, pc_q};
    end else if (taken) begin
      sel     = 1'b1;
      PC_disp = {1'b0, target};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_WAIT;
      pc_q       <= 8'd0;
      flush_left <= 2'd0;
      dec_valid  <= 1'b0;
      dec_op     <= 4'd0;
      dec_rd     <= 4'd0;
      dec_imm    <= 8'd0;
      halted     <= 1'b0;
    end else begin
      // pc_q freezes on the HALT word's own address so the refetch target is the HALT itself.
      if (state != S_HALT && !halt_now)
        pc_q <= PC;

      dec_valid <= (state == S_RUN);
      dec_op    <= (state == S_RUN) ? inst[15:12] : 4'd0;
      dec_rd    <= (state == S_RUN) ? inst[11:8]  : 4'd0;
      dec_imm   <= (state == S_RUN) ? inst[7:0]   : 8'd0;

      case (state)
        S_WAIT: state <= S_RUN;
        S_RUN: begin
          if (taken) begin
            state      <= S_FLUSH;
            flush_left <= 2'(FLUSH_CYCLES);
          end else if (halt_now) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_left <= 2'd1) begin
            state      <= S_RUN;
            flush_left <= 2'd0;
          end else begin
            flush_left <= flush_left - 2'd1;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef DECODE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (taken && taken_cnt != 16'hFFFF)
        taken_cnt <= taken_cnt + 16'd1;
      if ((state == S_WAIT || state == S_FLUSH) && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_branch.sv
// tb/tb_decode_branch.sv - self-checking bench for decode_branch with a fetch/ROM model
// Honours DECODE_PERF_EN to also check the performance counters.
module tb_decode_branch;

  localparam int         FC  = 2;
  localparam logic [3:0] HOP = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  PC = 8'd0;
  logic [15:0] inst = 16'd0;
  logic        z_flag = 1'b0;
  logic        sel;
  logic [8:0]  PC_disp;
  logic        dec_valid;
  logic [3:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [7:0]  dec_imm;
  logic        halted;
`ifdef DECODE_PERF_EN
  logic [15:0] taken_cnt;
  logic [15:0] flush_cnt;
`endif

  decode_branch #(.FLUSH_CYCLES(FC), .HALT_OP(HOP)) dut (
    .clk(clk), .rst(rst), .PC(PC), .inst(inst), .z_flag(z_flag),
    .sel(sel), .PC_disp(PC_disp), .dec_valid(dec_valid),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_imm(dec_imm), .halted(halted)
`ifdef DECODE_PERF_EN
    , .taken_cnt(taken_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: program memory, fetch unit and decode-stage bookkeeping.
  logic [15:0] rom [256];
  logic        zmap [256];
  bit          use_zmap;
  int          skip;
  bit          m_halt;
  logic [7:0]  hold_addr;
  logic [7:0]  fpc;
  logic [7:0]  addr;
  bit          stale;
  bit          p_valid;
  logic [15:0] p_word;
  int          m_taken;
  int          m_flush;

  task automatic reset_model();
    skip = 1; m_halt = 0; hold_addr = 0; fpc = 0; addr = 0; stale = 1;
    p_valid = 0; p_word = 0; m_taken = 0; m_flush = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_sel", sel, 0);
    check("rst_disp", PC_disp, 0);
    check("rst_valid", dec_valid, 0);
    check("rst_fields", {dec_op, dec_rd, dec_imm}, 0);
    check("rst_halted", halted, 0);
`ifdef DECODE_PERF_EN
    check("rst_taken_cnt", taken_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
`endif
    reset_model();
    PC = 8'd0; inst = 16'd0; z_flag = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic step();
    logic [15:0] w;
    logic [3:0]  op;
    bit          tk;
    bit          e_sel;
    logic [8:0]  e_disp;
    bit          n_valid;
    bit          h_now;
    int          tk0;
    int          fl0;
    int          t;
    h_now = m_halt; tk0 = m_taken; fl0 = m_flush;
    w = stale ? 16'($urandom) : rom[addr];
    PC = fpc; inst = w;
    z_flag = use_zmap ? zmap[addr] : 1'($urandom);
    e_sel = 0; e_disp = 0; n_valid = 0;
    if (m_halt) begin
      e_sel = 1; e_disp = {1'b0, hold_addr};
    end else if (skip > 0) begin
      skip--; m_flush++;
    end else begin
      n_valid = 1;
      op = w[15:12];
      tk = (op == 4'hC) || (op == 4'hD && z_flag) || (op == 4'hE && !z_flag);
      if (tk) begin
        t = (int'(addr) + int'($signed(w[7:0]))) & 255;
        e_sel = 1; e_disp = 9'(t);
        skip = FC; m_taken++;
      end else if (op == HOP) begin
        m_halt = 1; hold_addr = addr;
      end
    end
    #3;
    check("sel", sel, e_sel);
    check("PC_disp", PC_disp, e_disp);
    check("dec_valid", dec_valid, p_valid);
    check("dec_fields", {dec_op, dec_rd, dec_imm}, p_word);
    check("halted", halted, h_now);
`ifdef DECODE_PERF_EN
    check("taken_cnt", taken_cnt, tk0);
    check("flush_cnt", flush_cnt, fl0);
`endif
    p_valid = n_valid;
    p_word  = n_valid ? w : 16'd0;
    addr  = fpc;
    fpc   = e_sel ? e_disp[7:0] : fpc + 8'd1;
    stale = 0;
    @(posedge clk); #1;
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 16'h1000 | 16'(i);
      zmap[i] = 1'b0;
    end
  endtask

  initial begin
    use_zmap = 1;
    reset_model();

    // Program A: first decode, JMP with wrong-path JMP ignored, second JMP, HALT.
    fill_nops();
    rom[8'h00] = 16'h1234;
    rom[8'h01] = 16'hC00F;
    rom[8'h02] = 16'hC0F0;
    rom[8'h10] = 16'hC0F0;
    rom[8'h11] = 16'hC005;
    rom[8'h12] = 16'hC0F0;
    rom[8'h17] = 16'hF000;
    #2;
    do_reset();
    step();
    step();
    check("first_op", dec_op, 4'h1);
    check("first_rd", dec_rd, 4'h2);
    check("first_imm", dec_imm, 8'h34);
    for (int i = 0; i < 12; i++) step();

    // Program B: BZ taken backwards to 0xFE region, BNZ wraps forward past 0xFF.
    fill_nops();
    rom[8'h02] = 16'hD0FC; zmap[8'h02] = 1'b1;
    rom[8'hFF] = 16'hE003;
    rom[8'h03] = 16'hF000;
    do_reset();
    for (int i = 0; i < 14; i++) step();

    // Program C: same BZ with z=0 falls through, HALT at 0x20, reset mid-HALT.
    fill_nops();
    rom[8'h02] = 16'hD0FC;
    rom[8'h20] = 16'hF000;
    do_reset();
    for (int i = 0; i < 38; i++) step();
    check("halt_disp", PC_disp, 9'h020);
    check("halt_sel", sel, 1);
    check("halt_flag", halted, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // Random programs with random z_flag.
    use_zmap = 0;
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i] = 16'($urandom);
        if (rom[i][15:12] == HOP && $urandom_range(0, 7) != 0) rom[i][15:12] = 4'h0;
      end
      do_reset();
      for (int i = 0; i < 50; i++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
